dvp_capture: RTL and testbench

//  Camera-side capture stage. Samples the sensor DVP bus (VSYNC/HREF/PIXDATA) on the pixel clock,

---
 rtl/dvp_capture.sv | 195 +++++++++++++++++++
 tb/tb_dvp_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture.sv
// DVP camera capture: registers the sensor bus, locks to a frame boundary, skips start-up frames,
// assembles RAW10/RGB565 pixels, crops to H_RES x V_RES and flags mis-sized frames.
module dvp_capture #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 600,
  parameter int SKIP_FRAMES = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_mode,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [9:0]  I_pixdata,
  output logic        O_vs_n,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic [15:0] O_frame_cnt,
  output logic        O_size_err,
  output logic        O_running
);

  localparam logic [15:0] H_LIM     = 16'(H_RES);
  localparam logic [15:0] V_LIM     = 16'(V_RES);
  localparam logic [7:0]  SKIP_LAST = (SKIP_FRAMES > 0) ? 8'(SKIP_FRAMES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  skip_cnt_r, skip_cnt_s;
  logic        vsync_r, href_r;
  logic [9:0]  pix_r;
  logic        vs_act_d_r, href_eff_d_r;
  logic        phase_r;
  logic [7:0]  hi_byte_r;
  logic [15:0] hcnt_r, vcnt_r;
  logic        err_flag_r;

  logic        vs_act_s, fs_s, fe_s, run_s;
  logic        href_eff_s, line_end_s;
  logic        pix_done_s, de_s, line_err_s, frame_err_s;
  logic [15:0] pix_s, vcnt_end_s;
  logic        unused_pix_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic parity2(input logic [1:0] v);
    return ^v;
  endfunction

  // The two LSBs carry nothing in either pixel format.
  assign unused_pix_s = parity2(pix_r[1:0]);

  // Stage 1: sample the sensor bus once on PIXCLK
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vsync_r      <= ~VS_POL;
      href_r       <= 1'b0;
      pix_r        <= 10'd0;
      vs_act_d_r   <= 1'b0;
      href_eff_d_r <= 1'b0;
    end else begin
      vsync_r      <= I_vsync;
      href_r       <= I_href;
      pix_r        <= I_pixdata;
      vs_act_d_r   <= vs_act_s;
      href_eff_d_r <= href_eff_s;
    end
  end

  // Sync edges, pixel assembly, crop and size decisions
  always_comb begin
    vs_act_s   = (vsync_r == VS_POL);
    fs_s       = vs_act_d_r & ~vs_act_s;
    fe_s       = ~vs_act_d_r & vs_act_s;
    run_s      = (state_r == ST_RUN);
    // VSYNC arriving mid-line closes the line exactly as an HREF fall would.
    href_eff_s = href_r & ~vs_act_s;
    line_end_s = href_eff_d_r & ~href_eff_s;
    pix_done_s = 1'b0;
    pix_s      = 16'd0;
    if (href_eff_s) begin
      if (I_mode) begin
        pix_done_s = phase_r;
        pix_s      = {hi_byte_r, pix_r[9:2]};
      end else begin
        pix_done_s = 1'b1;
        pix_s      = {pix_r[9:5], pix_r[9:4], pix_r[9:5]};
      end
    end else begin
      pix_done_s = 1'b0;
    end
    de_s        = run_s & pix_done_s & (hcnt_r < H_LIM) & (vcnt_r < V_LIM);
    line_err_s  = run_s & line_end_s & ((hcnt_r != H_LIM) | phase_r);
    vcnt_end_s  = line_end_s ? sat_inc(vcnt_r) : vcnt_r;
    frame_err_s = run_s & fe_s & (err_flag_r | line_err_s | (vcnt_end_s != V_LIM));
  end

  // RGB565 byte phase and line/frame position counters
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      phase_r   <= 1'b0;
      hi_byte_r <= 8'd0;
      hcnt_r    <= 16'd0;
      vcnt_r    <= 16'd0;
    end else begin
      phase_r <= (href_eff_s && I_mode) ? ~phase_r : 1'b0;
      if (href_eff_s && !phase_r) begin
        hi_byte_r <= pix_r[9:2];
      end
      if (line_end_s) begin
        hcnt_r <= 16'd0;
      end else if (pix_done_s) begin
        hcnt_r <= sat_inc(hcnt_r);
      end
      if (fs_s) begin
        vcnt_r <= 16'd0;
      end else if (line_end_s) begin
        vcnt_r <= sat_inc(vcnt_r);
      end
    end
  end

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r    <= ST_WAIT;
      skip_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      skip_cnt_r <= skip_cnt_s;
    end
  end

  // FSM next state: output only ever starts on a frame start
  always_comb begin
    state_s    = state_r;
    skip_cnt_s = skip_cnt_r;
    case (state_r)
      ST_WAIT: begin
        if (fs_s) begin
          skip_cnt_s = 8'd0;
          state_s    = (SKIP_FRAMES == 0) ? ST_RUN : ST_SKIP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SKIP: begin
        if (fs_s && (skip_cnt_r == SKIP_LAST)) begin
          state_s = ST_RUN;
        end else if (fs_s) begin
          skip_cnt_s = skip_cnt_r + 8'd1;
        end else begin
          state_s = ST_SKIP;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_WAIT;
    endcase
  end

  // Stage 2: registered frame-buffer port and status
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_vs_n      <= 1'b1;
      O_de        <= 1'b0;
      O_data      <= 16'd0;
      O_frame_cnt <= 16'd0;
      O_size_err  <= 1'b0;
      O_running   <= 1'b0;
      err_flag_r  <= 1'b0;
    end else begin
      O_vs_n     <= run_s ? ~vs_act_s : 1'b1;
      O_de       <= de_s;
      O_size_err <= frame_err_s;
      O_running  <= (state_s == ST_RUN);
      if (de_s) begin
        O_data <= pix_s;
      end
      if (run_s && fe_s) begin
        O_frame_cnt <= O_frame_cnt + 16'd1;
        err_flag_r  <= 1'b0;
      end else if (line_err_s) begin
        err_flag_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Randomized directed bench for dvp_capture on a reduced 8x4 window with a pixel-queue reference model.
module tb_dvp_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;

  logic        I_clk = 1'b0;
  logic        I_rst_n, I_mode, I_vsync, I_href;
  logic [9:0]  I_pixdata;
  logic        O_vs_n, O_de, O_size_err, O_running;
  logic [15:0] O_data, O_frame_cnt;

  always #5 I_clk = ~I_clk;

  dvp_capture #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(SKIP), .VS_POL(1'b1)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_mode(I_mode), .I_vsync(I_vsync), .I_href(I_href),
    .I_pixdata(I_pixdata), .O_vs_n(O_vs_n), .O_de(O_de), .O_data(O_data),
    .O_frame_cnt(O_frame_cnt), .O_size_err(O_size_err), .O_running(O_running)
  );

  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pix;
  int          de_cnt = 0, exp_de = 0, sz_cnt = 0, exp_sz = 0, exp_frames = 0;
  int          vs_count = 0, cur_lines = 0;
  bit          cur_out = 1'b0, cur_err = 1'b0, sz_prev = 1'b0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every O_de must match the next expected pixel
  always @(negedge I_clk) begin
    if (I_rst_n === 1'b1) begin
      if (O_de === 1'b1) begin
        de_cnt++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL de_unexpected observed=1 expected=0 data=%0h", O_data);
        end
        if (exp_q.size() > 0) begin
          exp_pix = exp_q.pop_front();
          checks++;
          assert (O_data === exp_pix) else begin
            errors++;
            $error("FAIL pixel_data observed=%0h expected=%0h", O_data, exp_pix);
          end
        end
      end
      if (O_size_err === 1'b1) begin
        sz_cnt++;
        checks++;
        assert (sz_prev == 1'b0) else begin
          errors++;
          $error("FAIL size_err_width observed=2+ cycles expected=1 cycle");
        end
      end
      sz_prev = (O_size_err === 1'b1);
    end else begin
      sz_prev = 1'b0;
    end
  end

  task automatic step(input logic v, input logic h, input logic [9:0] d);
    I_vsync   = v;
    I_href    = h;
    I_pixdata = d;
    @(posedge I_clk);
    #1;
  endtask

  function automatic void expect_pix(input int npix, input logic [15:0] p);
    if (cur_out && cur_lines < V && npix < H) begin
      exp_q.push_back(p);
      exp_de++;
    end
  endfunction

  task automatic send_line(input int nbeats, input bit keep_href);
    logic [9:0] d;
    logic [7:0] hi;
    int         npix;
    npix = 0;
    hi   = 8'd0;
    for (int i = 0; i < nbeats; i++) begin
      d = 10'($urandom);
      if (I_mode == 1'b0) begin
        expect_pix(npix, {d[9:5], d[9:4], d[9:5]});
        npix++;
      end else if (i % 2 == 0) begin
        hi = d[9:2];
      end else begin
        expect_pix(npix, {hi, d[9:2]});
        npix++;
      end
      step(1'b0, 1'b1, d);
    end
    if (npix != H || (I_mode == 1'b1 && nbeats % 2 == 1)) cur_err = 1'b1;
    cur_lines++;
    if (!keep_href) repeat ($urandom_range(3, 1)) step(1'b0, 1'b0, 10'd0);
  endtask

  // A VSYNC pulse ends the current frame and starts the next one.
  task automatic vsync_pulse(input bit hold_href);
    bit run_exp;
    run_exp = (vs_count > SKIP);
    if (cur_out) begin
      exp_frames++;
      if (cur_err || cur_lines != V) exp_sz++;
    end
    step(1'b1, hold_href, 10'($urandom));
    step(1'b1, 1'b0, 10'd0);
    chk(32'(O_vs_n), 32'(!run_exp), "vs_n_in_blank");
    chk(32'(O_running), 32'(run_exp), "running");
    step(1'b1, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0);
    chk(32'(O_frame_cnt), 32'(exp_frames), "frame_cnt");
    chk(32'(sz_cnt), 32'(exp_sz), "size_err_count");
    chk(32'(de_cnt), 32'(exp_de), "de_count");
    chk(32'(exp_q.size()), 32'd0, "pixels_pending");
    vs_count++;
    cur_out   = (vs_count > SKIP);
    cur_err   = 1'b0;
    cur_lines = 0;
  endtask

  task automatic do_reset(input logic mode);
    I_rst_n = 1'b0;
    #1;
    chk(32'(O_de), 32'd0, "rst_de");
    chk(32'(O_vs_n), 32'd1, "rst_vs_n");
    chk(32'(O_running), 32'd0, "rst_running");
    chk(32'(O_frame_cnt), 32'd0, "rst_frame_cnt");
    chk(32'(O_size_err), 32'd0, "rst_size_err");
    exp_de     = exp_de - exp_q.size();
    exp_q.delete();
    vs_count   = 0;
    cur_out    = 1'b0;
    cur_err    = 1'b0;
    cur_lines  = 0;
    exp_frames = 0;
    I_mode     = mode;
    step(1'b0, I_href, 10'($urandom));
    step(1'b0, I_href, 10'($urandom));
    I_rst_n = 1'b1;
  endtask

  initial begin
    I_rst_n = 1'b0; I_mode = 1'b0; I_vsync = 1'b0; I_href = 1'b0; I_pixdata = 10'd0;
    repeat (3) @(posedge I_clk);
    #1;
    chk(32'(O_vs_n), 32'd1, "init_vs_n");
    chk(32'(O_de), 32'd0, "init_de");
    chk(32'(O_data), 32'd0, "init_data");
    chk(32'(O_frame_cnt), 32'd0, "init_frame_cnt");
    chk(32'(O_size_err), 32'd0, "init_size_err");
    chk(32'(O_running), 32'd0, "init_running");
    I_rst_n = 1'b1;
    step(1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0);

    // RAW10: two skipped frames then one full output frame
    repeat (3) begin
      vsync_pulse(1'b0);
      repeat (V) send_line(H, 1'b0);
    end
    vsync_pulse(1'b0);
    chk(32'(de_cnt), 32'(H * V), "t1_de_total");
    chk(32'(O_frame_cnt), 32'd1, "t1_frame_cnt");
    chk(32'(sz_cnt), 32'd0, "t1_no_size_err");

    // RAW10 oversize frame: cropped, then flagged
    repeat (V + 2) send_line(H + 2, 1'b0);
    vsync_pulse(1'b0);
    chk(32'(sz_cnt), 32'd1, "t3_size_err");

    // VSYNC while HREF high part-way through a line
    send_line(H, 1'b0);
    send_line(H / 2, 1'b1);
    vsync_pulse(1'b1);
    chk(32'(sz_cnt), 32'd2, "t6_size_err");
    repeat (V) send_line(H, 1'b0);
    vsync_pulse(1'b0);
    chk(32'(sz_cnt), 32'd2, "t6_clean_frame");

    // Reset mid-line in RUN, switching to RGB565
    send_line(H, 1'b0);
    send_line(5, 1'b1);
    chk(32'(O_de), 32'd1, "t5_de_before_rst");
    do_reset(1'b1);
    send_line(3, 1'b0);
    repeat (3) begin
      vsync_pulse(1'b0);
      if (vs_count <= SKIP) repeat (V) send_line(2 * H, 1'b0);
    end

    // RGB565 latency: F8,1F -> F81F two clocks after the second beat
    exp_q.push_back(16'hF81F);
    exp_de++;
    step(1'b0, 1'b1, {8'hF8, 2'b11});
    step(1'b0, 1'b1, {8'h1F, 2'b00});
    chk(32'(O_de), 32'd0, "t2_de_early");
    step(1'b0, 1'b0, 10'd0);
    chk(32'(O_de), 32'd1, "t2_de_on_time");
    chk(32'(O_data), 32'hF81F, "t2_data");
    step(1'b0, 1'b0, 10'd0);
    chk(32'(O_de), 32'd0, "t2_de_single");
    step(1'b0, 1'b0, 10'd0);
    cur_lines++;
    cur_err = 1'b1;
    repeat (V - 1) send_line(2 * H, 1'b0);
    vsync_pulse(1'b0);

    // RGB565 line with an odd trailing byte
    send_line(2 * H + 1, 1'b0);
    repeat (V - 1) send_line(2 * H, 1'b0);
    vsync_pulse(1'b0);
    chk(32'(sz_cnt), 32'd4, "t4_size_err");
    repeat (V) send_line(2 * H, 1'b0);
    vsync_pulse(1'b0);
    chk(32'(O_frame_cnt), 32'd3, "t4_frame_cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
